// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes, instruction field layout
// and register codes used by the fetch/decode path.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_MOV = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_CPL = 4'h7,
    OP_SHL = 4'h8,
    OP_MUL = 4'hA,
    OP_MVI = 4'hC
  } opcode_t;

  localparam logic [15:0] HALT_WORD = 16'h0000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 6;
  localparam int SRC_MSB = 5;
  localparam int SRC_LSB = 0;

  localparam logic [5:0] REG_A = 6'h3F;
  localparam logic [5:0] REG_B = 6'h3E;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction queue of {instr, pc}; slot 0 is always the head.
// Flush wins over push/pop in the same cycle.
module fetch_queue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [1:0]         count
);

  logic [INSTR_W-1:0] instr0, instr1;
  logic [ADDR_W-1:0]  pc0, pc1;
  logic               do_pop, do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      instr0 <= '0;
      instr1 <= '0;
      pc0    <= '0;
      pc1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          // count stays put; the new word lands behind whatever remains
          if (count == 2'd1) begin
            instr0 <= push_instr;
            pc0    <= push_pc;
          end else begin
            instr0 <= instr1;
            pc0    <= pc1;
            instr1 <= push_instr;
            pc1    <= push_pc;
          end
        end
        2'b01: begin
          instr0 <= instr1;
          pc0    <= pc1;
          count  <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            instr0 <= push_instr;
            pc0    <= push_pc;
          end else begin
            instr1 <= push_instr;
            pc1    <= push_pc;
          end
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head_instr = instr0;
  assign head_pc    = pc0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous program ROM and
// queues returned words for decode. Halt-on-zero is built with FETCH_HALT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               rom_read,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [3:0]         ir_opcode,
  output logic [5:0]         ir_dest,
  output logic [5:0]         ir_src,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               halted
);

  logic [ADDR_W-1:0]  pc, inflight_pc;
  logic               inflight, squash, halted_q;
  logic [1:0]         count;
  logic               pop_req, issue, capture, halt_hit, push;
  logic [2:0]         occupancy;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_pc;

  assign ir_valid = (count != 2'd0);
  assign pop_req  = ir_valid && ir_ready;

  // Slots that will be taken once this cycle's pop and the inflight word settle.
  assign occupancy = 3'(count) + 3'(inflight) - 3'(pop_req);
  assign issue     = run && !halted_q && !redirect_valid && !rst && (occupancy <= 3'd1);
  assign capture   = inflight && !squash && !halted_q && !redirect_valid;

`ifdef FETCH_HALT_EN
  assign halt_hit = capture && (rom_data == INSTR_W'(HALT_WORD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted_q <= 1'b0;
    else if (redirect_valid)
      halted_q <= 1'b0;
    else if (halt_hit)
      halted_q <= 1'b1;
  end
`else
  assign halt_hit = 1'b0;
  assign halted_q = 1'b0;
`endif

  assign push = capture && !halt_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
    end else begin
      inflight <= issue;
      squash   <= redirect_valid && inflight;
      if (issue)
        inflight_pc <= pc;
      // A read issued alongside the halt capture is dropped, so the PC holds at halt+1.
      if (redirect_valid)
        pc <= redirect_addr;
      else if (issue && !halt_hit)
        pc <= pc + ADDR_W'(1);
    end
  end

  fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_instr (rom_data),
    .push_pc    (inflight_pc),
    .pop        (pop_req && !redirect_valid),
    .flush      (redirect_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  assign rom_read  = issue;
  assign rom_addr  = pc;
  assign ir_instr  = head_instr;
  assign ir_pc     = head_pc;
  assign ir_opcode = head_instr[OPC_MSB:OPC_LSB];
  assign ir_dest   = head_instr[DST_MSB:DST_LSB];
  assign ir_src    = head_instr[SRC_MSB:SRC_LSB];
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: ROM model plus an in-order address/word reference.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, run, redirect_valid, ir_ready;
  logic [7:0]  redirect_addr;
  logic        rom_read, ir_valid, halted;
  logic [7:0]  rom_addr, ir_pc;
  logic [15:0] rom_data, ir_instr;
  logic [3:0]  ir_opcode;
  logic [5:0]  ir_dest, ir_src;

  int checks = 0;
  int errors = 0;
  logic [15:0] rom [256];

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_read) rom_data <= rom[rom_addr];

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .rom_read       (rom_read),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_instr       (ir_instr),
    .ir_opcode      (ir_opcode),
    .ir_dest        (ir_dest),
    .ir_src         (ir_src),
    .ir_pc          (ir_pc),
    .halted         (halted)
  );

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom_range(65535, 1));
    rom[5] = 16'h2081;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b1; ir_ready = 1'b1; redirect_valid = 1'b0; redirect_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    fill_rom();
    rst = 1'b1; run = 1'b1; ir_ready = 1'b1; redirect_valid = 1'b0; redirect_addr = 8'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rom_read !== 1'b0) begin errors++; $display("FAIL reset_rom_read got=%b exp=0", rom_read); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr got=%h exp=00", rom_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
    checks++; if (ir_instr !== 16'h0 || ir_pc !== 8'h0) begin errors++; $display("FAIL reset_ir got instr=%h pc=%h exp 0/0", ir_instr, ir_pc); end
    checks++; if ({ir_opcode, ir_dest, ir_src} !== 16'h0) begin errors++; $display("FAIL reset_fields got=%h/%h/%h exp 0", ir_opcode, ir_dest, ir_src); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (rom_read !== 1'b1 || rom_addr !== 8'h00) begin
          errors++; $display("FAIL first_issue got read=%b addr=%h exp 1/00", rom_read, rom_addr);
        end
      end
      checks++;
      if (ir_valid !== (c == 2)) begin errors++; $display("FAIL first_valid_latency cycle=%0d got=%b exp=%b", c, ir_valid, c == 2); end
      if (c == 2) begin
        checks++;
        if (ir_pc !== 8'h00 || ir_instr !== rom[0]) begin
          errors++; $display("FAIL first_word got pc=%h instr=%h exp 00/%h", ir_pc, ir_instr, rom[0]);
        end
      end
      @(posedge clk); #1;
    end
    // asynchronous reset in the middle of a cycle
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rom_read !== 1'b0 || ir_valid !== 1'b0 || rom_addr !== 8'h00) begin
      errors++; $display("FAIL async_reset got read=%b valid=%b addr=%h exp 0/0/00", rom_read, ir_valid, rom_addr);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ir_valid !== (c == 2) || (c == 2 && ir_pc !== 8'h00)) begin
        errors++; $display("FAIL reset_restart cycle=%0d got valid=%b pc=%h", c, ir_valid, ir_pc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream();
    logic [7:0]  exp_pc, iss_pc;
    logic [15:0] w;
    int ndel;
    fill_rom();
    do_reset();
    exp_pc = 8'h00; iss_pc = 8'h00; ndel = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (rom_read !== 1'b1 || rom_addr !== iss_pc) begin
        errors++; $display("FAIL stream_issue cycle=%0d got read=%b addr=%h exp 1/%h", c, rom_read, rom_addr, iss_pc);
      end
      iss_pc = iss_pc + 8'd1;
      if (ir_valid === 1'b1) begin
        w = rom[exp_pc];
        checks++;
        if (ir_pc !== exp_pc || ir_instr !== w) begin
          errors++; $display("FAIL stream_word got pc=%h instr=%h exp %h/%h", ir_pc, ir_instr, exp_pc, w);
        end
        checks++;
        if (ir_opcode !== w[15:12] || ir_dest !== w[11:6] || ir_src !== w[5:0]) begin
          errors++; $display("FAIL stream_fields got %h/%h/%h for word %h", ir_opcode, ir_dest, ir_src, w);
        end
        if (exp_pc == 8'h05) begin
          checks++;
          if (ir_opcode !== 4'h2 || ir_dest !== 6'h02 || ir_src !== 6'h01) begin
            errors++; $display("FAIL fields_2081 got %h/%h/%h exp 2/02/01", ir_opcode, ir_dest, ir_src);
          end
        end
        exp_pc = exp_pc + 8'd1; ndel++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ndel != 38) begin errors++; $display("FAIL stream_throughput got=%0d exp=38", ndel); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_pc, iss_pc;
    int issued, delivered;
    fill_rom();
    do_reset();
    exp_pc = 8'h00; iss_pc = 8'h00; issued = 0; delivered = 0;
    for (int c = 0; c < 90; c++) begin
      if (c >= 12 && c < 17) ir_ready = 1'b0;
      else if (c < 40) ir_ready = 1'b1;
      else ir_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (c == 16) begin
        checks++;
        if (rom_read !== 1'b0) begin errors++; $display("FAIL bp_full_read got=%b exp=0", rom_read); end
      end
      if (rom_read === 1'b1) begin
        checks++;
        if (rom_addr !== iss_pc) begin errors++; $display("FAIL bp_issue got=%h exp=%h", rom_addr, iss_pc); end
        iss_pc = iss_pc + 8'd1; issued++;
      end
      if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
        checks++;
        if (ir_pc !== exp_pc || ir_instr !== rom[exp_pc]) begin
          errors++; $display("FAIL bp_word got pc=%h instr=%h exp %h/%h", ir_pc, ir_instr, exp_pc, rom[exp_pc]);
        end
        exp_pc = exp_pc + 8'd1; delivered++;
      end
      checks++;
      if (issued - delivered > 2) begin errors++; $display("FAIL bp_overflow got outstanding=%0d exp<=2", issued - delivered); end
      @(posedge clk); #1;
    end
    checks++;
    if (delivered < 40) begin errors++; $display("FAIL bp_progress got=%0d exp>=40", delivered); end
  endtask

  task automatic test_redirect();
    logic [7:0] exp_pc, iss_pc;
    int rd_c;
    fill_rom();
    do_reset();
    exp_pc = 8'h00; iss_pc = 8'h00; rd_c = -100;
    for (int c = 0; c < 100; c++) begin
      redirect_valid = (c % 20 == 10);
      if (redirect_valid) redirect_addr = (c == 10) ? 8'h12 : 8'($urandom_range(255, 0));
      ir_ready = (c < 30) ? 1'b1 : 1'($urandom_range(1, 0));
      @(negedge clk);
      if (redirect_valid) begin
        checks++;
        if (rom_read !== 1'b0) begin errors++; $display("FAIL redirect_no_issue got=%b exp=0", rom_read); end
        exp_pc = redirect_addr; iss_pc = redirect_addr; rd_c = c;
      end else begin
        if (c == rd_c + 1) begin
          checks++;
          if (rom_read !== 1'b1 || rom_addr !== exp_pc) begin
            errors++; $display("FAIL redirect_issue got read=%b addr=%h exp 1/%h", rom_read, rom_addr, exp_pc);
          end
        end
        if (c == rd_c + 1 || c == rd_c + 2) begin
          checks++;
          if (ir_valid !== 1'b0) begin errors++; $display("FAIL redirect_flush got valid=%b pc=%h exp 0", ir_valid, ir_pc); end
        end
        if (c == rd_c + 3) begin
          checks++;
          if (ir_valid !== 1'b1 || ir_pc !== exp_pc) begin
            errors++; $display("FAIL redirect_target got valid=%b pc=%h exp 1/%h", ir_valid, ir_pc, exp_pc);
          end
        end
        if (rom_read === 1'b1) begin
          checks++;
          if (rom_addr !== iss_pc) begin errors++; $display("FAIL redirect_seq_issue got=%h exp=%h", rom_addr, iss_pc); end
          iss_pc = iss_pc + 8'd1;
        end
        if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
          checks++;
          if (ir_pc !== exp_pc || ir_instr !== rom[exp_pc]) begin
            errors++; $display("FAIL redirect_word got pc=%h instr=%h exp %h/%h", ir_pc, ir_instr, exp_pc, rom[exp_pc]);
          end
          exp_pc = exp_pc + 8'd1;
        end
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc, wrap_exp [3];
    int k, ndel;
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00;
    fill_rom();
    do_reset();
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_addr = 8'hFE;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_pc = 8'hFE; k = 0; ndel = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rom_read === 1'b1 && k < 3) begin
        checks++;
        if (rom_addr !== wrap_exp[k]) begin errors++; $display("FAIL wrap_issue idx=%0d got=%h exp=%h", k, rom_addr, wrap_exp[k]); end
        k++;
      end
      if (ir_valid === 1'b1) begin
        checks++;
        if (ir_pc !== exp_pc || ir_instr !== rom[exp_pc]) begin
          errors++; $display("FAIL wrap_word got pc=%h instr=%h exp %h/%h", ir_pc, ir_instr, exp_pc, rom[exp_pc]);
        end
        exp_pc = exp_pc + 8'd1; ndel++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (k != 3 || ndel < 3) begin errors++; $display("FAIL wrap_progress got issues=%0d words=%0d exp 3/>=3", k, ndel); end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    logic [7:0] exp_pc, iss_pc;
    logic seen;
    fill_rom();
    rom[8'h0A] = 16'h0000;
    do_reset();
    exp_pc = 8'h00; iss_pc = 8'h00; seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      ir_ready = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      if (halted === 1'b1) seen = 1'b1;
      if (seen) begin
        checks++;
        if (rom_read !== 1'b0) begin errors++; $display("FAIL halt_no_read got=%b addr=%h exp 0", rom_read, rom_addr); end
      end
      if (rom_read === 1'b1) begin
        checks++;
        if (rom_addr !== iss_pc) begin errors++; $display("FAIL halt_issue got=%h exp=%h", rom_addr, iss_pc); end
        iss_pc = iss_pc + 8'd1;
      end
      if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
        checks++;
        if (exp_pc >= 8'h0A || ir_pc !== exp_pc || ir_instr !== rom[exp_pc]) begin
          errors++; $display("FAIL halt_word got pc=%h instr=%h exp %h (below 0a)", ir_pc, ir_instr, exp_pc);
        end
        exp_pc = exp_pc + 8'd1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_pc !== 8'h0A) begin errors++; $display("FAIL halt_delivered got next=%h exp=0a", exp_pc); end
    checks++;
    if (halted !== 1'b1 || ir_valid !== 1'b0 || rom_addr !== 8'h0B) begin
      errors++; $display("FAIL halt_state got halted=%b valid=%b addr=%h exp 1/0/0b", halted, ir_valid, rom_addr);
    end
    redirect_valid = 1'b1; redirect_addr = 8'h00;
    @(negedge clk);
    checks++;
    if (rom_read !== 1'b0) begin errors++; $display("FAIL halt_redirect_cycle got read=%b exp 0", rom_read); end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || rom_read !== 1'b1 || rom_addr !== 8'h00) begin
      errors++; $display("FAIL halt_restart got halted=%b read=%b addr=%h exp 0/1/00", halted, rom_read, rom_addr);
    end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_halt();
    logic [7:0] exp_pc;
    fill_rom();
    rom[8'h0A] = 16'h0000;
    do_reset();
    exp_pc = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (halted !== 1'b0) begin errors++; $display("FAIL nohalt_flag got=%b exp=0", halted); end
      if (ir_valid === 1'b1) begin
        checks++;
        if (ir_pc !== exp_pc || ir_instr !== rom[exp_pc]) begin
          errors++; $display("FAIL nohalt_word got pc=%h instr=%h exp %h/%h", ir_pc, ir_instr, exp_pc, rom[exp_pc]);
        end
        exp_pc = exp_pc + 8'd1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_pc < 8'h0C) begin errors++; $display("FAIL nohalt_progress got next=%h exp>=0c", exp_pc); end
  endtask
`endif

  initial begin
    rst = 1'b1; run = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
    rom_data = 16'h0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
